adc9653_spi_cfg: RTL and testbench



---
 rtl/adc9653_spi_cfg.sv | 228 ++++++++++++++++++++++
 tb/tb_adc9653_spi_cfg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc9653_spi_cfg.sv
// AD9653 3-wire SPI configuration sequencer: fixed power-up writes, then host single-register access.
// Optional init readback verification with sticky cfg_err when ADC9653_SPI_VERIFY_EN is defined.
module adc9653_spi_cfg #(
  parameter int CLK_DIV  = 5,
  parameter int RST_WAIT = 2000,
  parameter int GAP_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_rw,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        init_done,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdio_o,
  output logic        spi_sdio_t,
  input  logic        spi_sdio_i
`ifdef ADC9653_SPI_VERIFY_EN
  ,
  output logic        cfg_err
`endif
);

  localparam logic [2:0] S_INIT_LOAD = 3'd0;
  localparam logic [2:0] S_SHIFT     = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_RST_DLY   = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_IDLE      = 3'd5;

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] RST_LAST = 32'(RST_WAIT - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);

`ifdef ADC9653_SPI_VERIFY_EN
  localparam logic [2:0] LAST_STEP = 3'd5;
`else
  localparam logic [2:0] LAST_STEP = 3'd3;
`endif

  // Entry = {rw, addr, data}; for readback steps the data field is the expected value.
  function automatic logic [21:0] f_init_step(input logic [2:0] step);
    logic [21:0] v;
    case (step)
`ifdef ADC9653_SPI_VERIFY_EN
      3'd0:    v = {1'b0, 13'h000, 8'h3C};
      3'd1:    v = {1'b0, 13'h014, 8'h01};
      3'd2:    v = {1'b1, 13'h014, 8'h01};
      3'd3:    v = {1'b0, 13'h021, 8'h30};
      3'd4:    v = {1'b1, 13'h021, 8'h30};
      default: v = {1'b0, 13'h0FF, 8'h01};
`else
      3'd0:    v = {1'b0, 13'h000, 8'h3C};
      3'd1:    v = {1'b0, 13'h014, 8'h01};
      3'd2:    v = {1'b0, 13'h021, 8'h30};
      default: v = {1'b0, 13'h0FF, 8'h01};
`endif
    endcase
    return v;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic [31:0] r_cnt;
  logic [4:0]  r_bit;
  logic [23:0] r_shift;
  logic        r_rw;
  logic        r_is_srst;
  logic [7:0]  r_rx;
  logic [7:0]  r_rdata;
  logic        r_csb;
  logic        r_sclk;
  logic        r_sdio_o;
  logic        r_sdio_t;
  logic        r_init_done;
`ifdef ADC9653_SPI_VERIFY_EN
  logic [7:0]  r_exp;
  logic        r_cfg_err;
`endif

  logic [21:0] w_init_ent;
  logic        w_ld_rw;
  logic [12:0] w_ld_addr;
  logic [7:0]  w_ld_data;
  logic [23:0] w_ld_frame;
  logic        w_start;
  logic [7:0]  w_rx_next;

  always_comb begin
    w_init_ent = f_init_step(r_idx);
    if (r_state == S_IDLE) begin
      w_ld_rw   = req_rw;
      w_ld_addr = req_addr;
      w_ld_data = req_wdata;
    end else begin
      w_ld_rw   = w_init_ent[21];
      w_ld_addr = w_init_ent[20:8];
      w_ld_data = w_init_ent[7:0];
    end
    w_ld_frame = {w_ld_rw, 2'b00, w_ld_addr, (w_ld_rw ? 8'h00 : w_ld_data)};
    w_start    = (r_state == S_INIT_LOAD) || ((r_state == S_IDLE) && req && r_init_done);
    w_rx_next  = {r_rx[6:0], spi_sdio_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT_LOAD;
      r_idx       <= 3'd0;
      r_cnt       <= 32'd0;
      r_bit       <= 5'd0;
      r_shift     <= 24'd0;
      r_rw        <= 1'b0;
      r_is_srst   <= 1'b0;
      r_rx        <= 8'd0;
      r_rdata     <= 8'd0;
      r_csb       <= 1'b1;
      r_sclk      <= 1'b0;
      r_sdio_o    <= 1'b0;
      r_sdio_t    <= 1'b0;
      r_init_done <= 1'b0;
`ifdef ADC9653_SPI_VERIFY_EN
      r_exp       <= 8'd0;
      r_cfg_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_INIT_LOAD, S_IDLE: begin
          if (w_start) begin
            r_shift   <= w_ld_frame;
            r_sdio_o  <= w_ld_frame[23];
            r_csb     <= 1'b0;
            r_sclk    <= 1'b0;
            r_bit     <= 5'd23;
            r_cnt     <= 32'd0;
            r_rw      <= w_ld_rw;
            r_is_srst <= (r_state == S_INIT_LOAD) && (r_idx == 3'd0);
`ifdef ADC9653_SPI_VERIFY_EN
            r_exp     <= w_ld_data;
`endif
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt != DIV_LAST) begin
            r_cnt <= r_cnt + 32'd1;
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_cnt  <= 32'd0;
          end else begin
            // End of a high phase: sample read data, then drop sclk and present the next bit.
            r_sclk <= 1'b0;
            r_cnt  <= 32'd0;
            if (r_rw && (r_bit <= 5'd7))
              r_rx <= w_rx_next;
            if (r_bit == 5'd0) begin
              if (r_rw && r_init_done)
                r_rdata <= w_rx_next;
`ifdef ADC9653_SPI_VERIFY_EN
              if (r_rw && !r_init_done && (w_rx_next != r_exp))
                r_cfg_err <= 1'b1;
`endif
              r_state <= S_HOLD;
            end else begin
              r_bit    <= r_bit - 5'd1;
              r_shift  <= {r_shift[22:0], 1'b0};
              r_sdio_o <= r_shift[22];
              if (r_rw && (r_bit == 5'd8))
                r_sdio_t <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == DIV_LAST) begin
            r_csb    <= 1'b1;
            r_sdio_t <= 1'b0;
            r_sdio_o <= 1'b0;
            r_cnt    <= 32'd0;
            r_state  <= r_is_srst ? S_RST_DLY : S_GAP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RST_DLY: begin
          if (r_cnt == RST_LAST) begin
            r_cnt   <= 32'd0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= 32'd0;
            if (!r_init_done && (r_idx != LAST_STEP)) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_INIT_LOAD;
            end else begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_INIT_LOAD;
      endcase
    end
  end

  // Host frames only exist after init, so a final-gap cycle with init_done set is a host completion.
  assign ack        = (r_state == S_GAP) && r_init_done && (r_cnt == GAP_LAST);
  assign rdata      = r_rdata;
  assign busy       = (r_state != S_IDLE);
  assign init_done  = r_init_done;
  assign spi_csb    = r_csb;
  assign spi_sclk   = r_sclk;
  assign spi_sdio_o = r_sdio_o;
  assign spi_sdio_t = r_sdio_t;
`ifdef ADC9653_SPI_VERIFY_EN
  assign cfg_err    = r_cfg_err;
`endif

endmodule

// File: tb/tb_adc9653_spi_cfg.sv
// Scoreboard bench for adc9653_spi_cfg: SPI frame monitor with ADC read model, ack/rdata checking.
// Covers ADC9653_SPI_VERIFY_EN builds as well (6 init frames, cfg_err).
module tb_adc9653_spi_cfg;
  localparam int CLK_DIV  = 2;
  localparam int RST_WAIT = 20;
  localparam int GAP_CYC  = 4;
`ifdef ADC9653_SPI_VERIFY_EN
  localparam int N_INIT = 6;
`else
  localparam int N_INIT = 4;
`endif

  typedef struct {
    logic [23:0] frame;
    logic        rd;
    int          min_gap;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b0;
  logic [12:0] req_addr = 13'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        init_done;
  logic        spi_csb;
  logic        spi_sclk;
  logic        spi_sdio_o;
  logic        spi_sdio_t;
  logic        spi_sdio_i = 1'b0;
`ifdef ADC9653_SPI_VERIFY_EN
  logic        cfg_err;
`endif

  adc9653_spi_cfg #(.CLK_DIV(CLK_DIV), .RST_WAIT(RST_WAIT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy), .init_done(init_done),
    .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_sdio_o(spi_sdio_o),
    .spi_sdio_t(spi_sdio_t), .spi_sdio_i(spi_sdio_i)
`ifdef ADC9653_SPI_VERIFY_EN
    , .cfg_err(cfg_err)
`endif
  );

  always #5 clk = ~clk;

  frm_t       q_frm[$];
  logic [7:0] q_ack[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] init_frame(input int k);
    logic [23:0] f;
`ifdef ADC9653_SPI_VERIFY_EN
    case (k)
      0: f = 24'h00003C;
      1: f = 24'h001401;
      2: f = 24'h801400;
      3: f = 24'h002130;
      4: f = 24'h802100;
      default: f = 24'h00FF01;
    endcase
`else
    case (k)
      0: f = 24'h00003C;
      1: f = 24'h001401;
      2: f = 24'h002130;
      default: f = 24'h00FF01;
    endcase
`endif
    return f;
  endfunction

  // Register contents the ADC model returns on reads.
  function automatic logic [7:0] adc_reg(input logic [12:0] a);
    case (a)
      13'h001: return 8'h92;
      13'h014: return 8'h01;
      13'h021: return 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_init();
    frm_t f;
    for (int k = 0; k < N_INIT; k++) begin
      f.frame   = init_frame(k);
      f.rd      = f.frame[23];
      f.min_gap = (k == 0) ? 0 : (k == 1) ? (RST_WAIT + GAP_CYC) : GAP_CYC;
      q_frm.push_back(f);
    end
  endtask

  task automatic push_host(input logic [23:0] frame, input logic [7:0] exp_rd);
    frm_t f;
    f.frame   = frame;
    f.rd      = frame[23];
    f.min_gap = GAP_CYC;
    q_frm.push_back(f);
    q_ack.push_back(exp_rd);
  endtask

  // Monitor state
  logic        in_frame = 1'b0;
  logic        prev_csb = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        t_bad = 1'b0;
  logic        exp_t;
  logic [23:0] shreg = 24'd0;
  logic [7:0]  resp = 8'd0;
  int          bitcnt = 0;
  int          gap_cnt = 0;
  int          frames_done = 0;
  int          ack_cnt = 0;
  frm_t        f_pop;

  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 1'b0;
      bitcnt     = 0;
      gap_cnt    = 0;
      prev_csb   = 1'b1;
      prev_sclk  = 1'b0;
      spi_sdio_i = 1'b0;
    end else begin
      if (prev_csb && !spi_csb) begin
        in_frame = 1'b1;
        bitcnt   = 0;
        shreg    = 24'd0;
        t_bad    = 1'b0;
        if (q_frm.size() > 0) chk("csb_gap", 32'(gap_cnt >= q_frm[0].min_gap), 32'd1);
        gap_cnt = 0;
      end
      if (spi_csb) gap_cnt++;
      if (in_frame && !prev_sclk && spi_sclk) begin
        shreg = {shreg[22:0], spi_sdio_o};
        bitcnt++;
        exp_t = (bitcnt >= 17 && q_frm.size() > 0) ? q_frm[0].rd : 1'b0;
        if (spi_sdio_t !== exp_t) t_bad = 1'b1;
        if (bitcnt == 16) resp = adc_reg(shreg[12:0]);
        if (bitcnt >= 17 && bitcnt <= 24) spi_sdio_i = resp[24 - bitcnt];
      end
      if (in_frame && !prev_csb && spi_csb) begin
        in_frame = 1'b0;
        frames_done++;
        spi_sdio_i = 1'b0;
        if (q_frm.size() == 0) begin
          chk("frame_unexpected", 32'(q_frm.size()), 32'd1);
        end else begin
          f_pop = q_frm.pop_front();
          $display("frame %0d: 0x%06h (expected 0x%06h)", frames_done, shreg, f_pop.frame);
          chk("frame", 32'(shreg), 32'(f_pop.frame));
          chk("sclk_edges", 32'(bitcnt), 32'd24);
          chk("sdio_t", 32'(t_bad), 32'd0);
        end
      end
      if (ack) begin
        ack_cnt++;
        if (q_ack.size() == 0) chk("ack_unexpected", 32'(q_ack.size()), 32'd1);
        else chk("rdata_at_ack", 32'(rdata), 32'(q_ack.pop_front()));
      end
      prev_csb  = spi_csb;
      prev_sclk = spi_sclk;
    end
  end

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done) break;
    end
    chk("init_done_seen", 32'(init_done), 32'd1);
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    chk("ack_seen", 32'(ack), 32'd1);
    req = 1'b0;
  endtask

  task automatic host_xfer(input logic rw, input logic [12:0] a, input logic [7:0] d,
                           input logic [23:0] exp_frame, input logic [7:0] exp_rd);
    int acks0;
    acks0 = ack_cnt;
    push_host(exp_frame, exp_rd);
    req_rw = rw; req_addr = a; req_wdata = d; req = 1'b1;
    wait_ack(2000);
    repeat (20) @(negedge clk);
    chk("ack_pulses", 32'(ack_cnt - acks0), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  int base;
  int acks_before;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csb", 32'(spi_csb), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_sdio_o", 32'(spi_sdio_o), 32'd0);
    chk("rst_sdio_t", 32'(spi_sdio_t), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
`ifdef ADC9653_SPI_VERIFY_EN
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
`endif

    push_init();
    base = frames_done;
    rst = 1'b0;
    wait_init(5000);
    chk("busy_at_init_done", 32'(busy), 32'd0);
    chk("init_frame_count", 32'(frames_done - base), 32'(N_INIT));
    chk("init_no_ack", 32'(ack_cnt), 32'd0);
`ifdef ADC9653_SPI_VERIFY_EN
    chk("cfg_err", 32'(cfg_err), 32'd1);
`endif

    host_xfer(1'b0, 13'h018, 8'h04, 24'h001804, 8'h00);
    host_xfer(1'b1, 13'h001, 8'h00, 24'h800100, 8'h92);
    host_xfer(1'b0, 13'h018, 8'h55, 24'h001855, 8'h92);

    // Reset in the middle of the second init frame, with a host request pending from cycle 5.
    rst = 1'b1;
    q_frm.delete();
    q_ack.delete();
    @(negedge clk);
    push_init();
    base = frames_done;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames_done == base + 1 && in_frame && bitcnt == 12) break;
    end
    chk("mid_frame_reached", 32'(bitcnt), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_csb", 32'(spi_csb), 32'd1);
    chk("midrst_sclk", 32'(spi_sclk), 32'd0);
    chk("midrst_sdio_t", 32'(spi_sdio_t), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    q_frm.delete();
    q_ack.delete();
    push_init();
    base = frames_done;
    acks_before = ack_cnt;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    push_host(24'h00050F, 8'h00);
    req_rw = 1'b0; req_addr = 13'h005; req_wdata = 8'h0F; req = 1'b1;
    wait_init(5000);
    chk("restart_frame_count", 32'(frames_done - base), 32'(N_INIT));
    chk("no_ack_during_init", 32'(ack_cnt - acks_before), 32'd0);
    wait_ack(2000);
    repeat (20) @(negedge clk);
    chk("early_req_frames", 32'(frames_done - base), 32'(N_INIT + 1));
    chk("early_req_acks", 32'(ack_cnt - acks_before), 32'd1);
    chk("frames_pending", 32'(q_frm.size()), 32'd0);
    chk("acks_pending", 32'(q_ack.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
